// File: rtl/scale_offset_pipe_if.sv
// Stream bundle for scale_offset_pipe: producer-side input beat and consumer-side output beat.
// A beat moves on a side when its valid and ready are both high at a rising clock edge; the
// sender keeps the beat's payload stable while valid is high and ready is low.
interface scale_offset_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CHW   = 2,
    parameter int CNTW  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CHW-1:0]   in_chan;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CHW-1:0]   out_chan;
    logic             out_clipped;
    logic [CNTW-1:0]  xfer_count;

    modport master (
        output in_valid, in_data, in_chan, in_sat, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_clipped, xfer_count
    );

    modport slave (
        input  in_valid, in_data, in_chan, in_sat, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_clipped, xfer_count
    );
endinterface

// File: rtl/scale_offset_pipe.sv
// Two-stage streaming converter out = SCALE*(in - OFFSET) with per-beat wrap/saturate,
// channel-tag passthrough and a completed-transfer counter.
module scale_offset_pipe #(
    parameter int WIDTH  = 8,
    parameter int SCALE  = 5,
    parameter int OFFSET = 32,
    parameter int CHW    = 2,
    parameter int CNTW   = 16
) (
    input logic             clk,
    input logic             rst,
    scale_offset_pipe_if.slave bus
);
    localparam int DW = WIDTH + 1;
    // Wide enough for SCALE * (+/- 2**WIDTH) plus a sign bit, and always >= WIDTH+3.
    localparam int PW = DW + $clog2(SCALE + 1) + 1;
    localparam logic signed [PW-1:0] SCALE_S = PW'(SCALE);

    logic                  s1_valid;
    logic signed [DW-1:0]  s1_diff;
    logic [CHW-1:0]        s1_chan;
    logic                  s1_sat;

    logic                  s2_valid;
    logic [WIDTH-1:0]      s2_data;
    logic [CHW-1:0]        s2_chan;
    logic                  s2_clipped;
    logic [CNTW-1:0]       count;

    logic                  s2_load;
    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic signed [PW-1:0]  prod;
    logic [WIDTH-1:0]      res_data;
    logic                  res_clipped;

    always_comb begin
        s2_load  = s1_valid && (!s2_valid || bus.out_ready);
        in_ready = !s1_valid || s2_load;
        in_fire  = bus.in_valid && in_ready;
        out_fire = s2_valid && bus.out_ready;
    end

    always_comb begin
        prod        = $signed({{(PW-DW){s1_diff[DW-1]}}, s1_diff}) * SCALE_S;
        res_data    = prod[WIDTH-1:0];
        res_clipped = 1'b0;
        if (s1_sat) begin
            if (prod[PW-1]) begin
                res_data    = '0;
                res_clipped = 1'b1;
            end else if (|prod[PW-2:WIDTH]) begin
                res_data    = '1;
                res_clipped = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_diff    <= '0;
            s1_chan    <= '0;
            s1_sat     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_chan    <= '0;
            s2_clipped <= 1'b0;
            count      <= '0;
        end else begin
            // S1 is either empty or handing its beat to S2 whenever in_ready is high.
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                s1_diff <= {1'b0, bus.in_data} - DW'(OFFSET);
                s1_chan <= bus.in_chan;
                s1_sat  <= bus.in_sat;
            end
            if (s2_load) begin
                s2_valid   <= 1'b1;
                s2_data    <= res_data;
                s2_chan    <= s1_chan;
                s2_clipped <= res_clipped;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
            if (out_fire) begin
                count <= count + CNTW'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid;
    assign bus.out_data    = s2_data;
    assign bus.out_chan    = s2_chan;
    assign bus.out_clipped = s2_clipped;
    assign bus.xfer_count  = count;
endmodule

// File: tb/tb_scale_offset_pipe.sv
// Directed and random checks of scale_offset_pipe: a default 8-bit instance and a
// WIDTH=12/SCALE=3/OFFSET=100 instance, each with an expected-beat queue.
module tb_scale_offset_pipe;
    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    logic [14:0] exp12_q[$];
    logic [15:0] exp_xfer;
    logic        acc;

    scale_offset_pipe_if #(.WIDTH(8),  .CHW(2), .CNTW(16)) bus ();
    scale_offset_pipe_if #(.WIDTH(12), .CHW(2), .CNTW(16)) bus12 ();

    scale_offset_pipe #(.WIDTH(8), .SCALE(5), .OFFSET(32), .CHW(2), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    scale_offset_pipe #(.WIDTH(12), .SCALE(3), .OFFSET(100), .CHW(2), .CNTW(16)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {chan, clipped, data} for SCALE*(d-OFFSET) in a w-bit result.
    function automatic logic [31:0] model(input int w, input int scale, input int off,
                                          input int d, input int c, input int s);
        int p;
        int mask;
        int r;
        int clip;
        p    = scale * (d - off);
        mask = (1 << w) - 1;
        r    = p & mask;
        clip = 0;
        if (s != 0) begin
            if (p < 0) begin
                r    = 0;
                clip = 1;
            end else if (p > mask) begin
                r    = mask;
                clip = 1;
            end
        end
        return 32'((c << (w + 1)) | (clip << w) | r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes mid-low-phase, then advance to the next falling edge.
    task automatic tick();
        logic [31:0] want;
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hxxxx_xxxx;
                check("sb8_beat", 32'({bus.out_chan, bus.out_clipped, bus.out_data}), want);
                exp_xfer = exp_xfer + 16'd1;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc = 1'b1;
                exp_q.push_back(11'(model(8, 5, 32, int'(bus.in_data), int'(bus.in_chan),
                                          int'(bus.in_sat))));
            end
            if (bus12.out_valid && bus12.out_ready) begin
                want = (exp12_q.size() > 0) ? 32'(exp12_q.pop_front()) : 32'hxxxx_xxxx;
                check("sb12_beat", 32'({bus12.out_chan, bus12.out_clipped, bus12.out_data}), want);
            end
            if (bus12.in_valid && bus12.in_ready) begin
                exp12_q.push_back(15'(model(12, 3, 100, int'(bus12.in_data), int'(bus12.in_chan),
                                            int'(bus12.in_sat))));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus12.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp12_q.delete();
        exp_xfer = '0;
    endtask

    task automatic send(input int d, input int c, input int s, input int max_cycles);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        bus.in_chan  = 2'(c);
        bus.in_sat   = 1'(s);
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (acc) break;
        end
        check("send_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bus.in_valid    = 1'b0;
        bus12.in_valid  = 1'b0;
        bus.out_ready   = 1'b1;
        bus12.out_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && exp12_q.size() == 0) break;
            tick();
        end
        check("drain_empty", 32'(exp_q.size() + exp12_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] hold;
        int sent;
        int cycles;
        logic pending;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_chan = '0;  bus.in_sat = 1'b0;
        bus.out_ready = 1'b0;
        bus12.in_valid = 1'b0; bus12.in_data = '0; bus12.in_chan = '0; bus12.in_sat = 1'b0;
        bus12.out_ready = 1'b0;
        exp_xfer = '0;
        acc = 1'b0;
        do_reset();

        check("rst_out_valid",   32'(bus.out_valid),   32'd0);
        check("rst_out_data",    32'(bus.out_data),    32'd0);
        check("rst_out_chan",    32'(bus.out_chan),    32'd0);
        check("rst_out_clipped", 32'(bus.out_clipped), 32'd0);
        check("rst_xfer_count",  32'(bus.xfer_count),  32'd0);
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);

        // Wrap mode, back-to-back 40, 0, 100.
        bus.out_ready = 1'b1;
        bus.in_sat = 1'b0; bus.in_chan = 2'd1; bus.in_valid = 1'b1;
        bus.in_data = 8'd40;  tick();
        check("wrap_lat_c1_valid", 32'(bus.out_valid), 32'd0);
        bus.in_data = 8'd0;   tick();
        check("wrap_c2_data", 32'(bus.out_data), 32'd40);
        check("wrap_c2_valid", 32'(bus.out_valid), 32'd1);
        bus.in_data = 8'd100; tick();
        check("wrap_c3_data", 32'(bus.out_data), 32'd96);
        check("wrap_c3_clipped", 32'(bus.out_clipped), 32'd0);
        bus.in_valid = 1'b0;  tick();
        check("wrap_c4_data", 32'(bus.out_data), 32'd84);
        tick();
        check("wrap_idle_valid", 32'(bus.out_valid), 32'd0);
        check("wrap_xfer", 32'(bus.xfer_count), 32'd3);

        // Saturate mode, same inputs.
        bus.in_sat = 1'b1; bus.in_chan = 2'd2; bus.in_valid = 1'b1;
        bus.in_data = 8'd40;  tick();
        bus.in_data = 8'd0;   tick();
        check("sat_c2_data", 32'(bus.out_data), 32'd40);
        check("sat_c2_clipped", 32'(bus.out_clipped), 32'd0);
        bus.in_data = 8'd100; tick();
        check("sat_c3_data", 32'(bus.out_data), 32'd0);
        check("sat_c3_clipped", 32'(bus.out_clipped), 32'd1);
        bus.in_valid = 1'b0;  tick();
        check("sat_c4_data", 32'(bus.out_data), 32'd255);
        check("sat_c4_clipped", 32'(bus.out_clipped), 32'd1);
        check("sat_c4_chan", 32'(bus.out_chan), 32'd2);
        drain(10);

        // Reset with two beats in flight: nothing stale may emerge.
        bus.out_ready = 1'b0;
        send(10, 1, 0, 4);
        send(200, 2, 1, 4);
        check("mid_full_valid", 32'(bus.out_valid), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_xfer", 32'(bus.xfer_count), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_stale", 32'(bus.out_valid), 32'd0);
        check("mid_xfer_after", 32'(bus.xfer_count), 32'd0);

        // Stall: consumer blocked for 5 cycles with the pipe full.
        do_reset();
        bus.out_ready = 1'b0;
        send(50, 3, 0, 4);
        send(60, 2, 1, 4);
        bus.in_valid = 1'b1; bus.in_data = 8'd70; bus.in_chan = 2'd1; bus.in_sat = 1'b0;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        hold = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_data", 32'(bus.out_data), 32'(hold));
            check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            check("stall_no_accept", 32'(acc), 32'd0);
        end
        bus.out_ready = 1'b1;
        send(70, 1, 0, 10);
        send(80, 0, 1, 10);
        drain(20);
        check("stall_xfer", 32'(bus.xfer_count), 32'd4);

        // Random valid/ready with mixed modes and channels.
        pending = 1'b0;
        sent = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                bus.in_data  = 8'($urandom_range(0, 255));
                bus.in_chan  = 2'($urandom_range(0, 3));
                bus.in_sat   = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
                pending = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cycles++;
            if (acc) begin
                pending = 1'b0;
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        check("rand_sent", 32'(sent), 32'd10000);
        drain(20);
        check("rand_xfer", 32'(bus.xfer_count), 32'(exp_xfer));
        check("rand_xfer_abs", 32'(bus.xfer_count), 32'((4 + 10000) % 65536));

        // Wider instance: WIDTH=12, SCALE=3, OFFSET=100, saturate.
        bus12.out_ready = 1'b1;
        bus12.in_sat = 1'b1; bus12.in_chan = 2'd3; bus12.in_valid = 1'b1;
        bus12.in_data = 12'd4095; tick();
        bus12.in_data = 12'd50;   tick();
        check("w12_c2_data", 32'(bus12.out_data), 32'd4095);
        check("w12_c2_clipped", 32'(bus12.out_clipped), 32'd1);
        bus12.in_data = 12'd200;  tick();
        check("w12_c3_data", 32'(bus12.out_data), 32'd0);
        check("w12_c3_clipped", 32'(bus12.out_clipped), 32'd1);
        bus12.in_valid = 1'b0;    tick();
        check("w12_c4_data", 32'(bus12.out_data), 32'd300);
        check("w12_c4_clipped", 32'(bus12.out_clipped), 32'd0);
        drain(10);
        check("w12_xfer", 32'(bus12.xfer_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
